modport_core: RTL and testbench
===============================

MODPORT_CORE -- requirements
Module: modport_core

Interface
REQ-001 SHALL provide one clock and an asynchronous, active-high reset, named clock and reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset; clears all state immediately.
REQ-004 mem_ins  input  32  RV32I instruction word located at the current PC; supplied by the instruction memory in the same cycle.
REQ-005 PC  output  32  fetch address; driven directly from the PC register.

Function
REQ-006 SHALL be a 4-stage in-order pipeline:
- IF: PC register; mem_ins captured into IF/ID.
- ID: decode and register-file read.
- EX: ALU and branch/jump resolution.
- WB: register-file write.
REQ-007 SHALL execute these instructions:
- LUI, AUIPC, JAL, JALR.
- BEQ, BNE, BLT, BGE, BLTU, BGEU.
- ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
- ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
REQ-008 SHALL treat all other instructions as NOPs with no state change: loads, stores, FENCE, SYSTEM and unknown opcodes.
REQ-009 Arithmetic SHALL be 32-bit with wrap-around; shift amounts SHALL use bits [4:0] only.
REQ-010 Register file SHALL be 32 x 32; x0 reads 0 and writes to x0 are discarded.
REQ-011 WB write and ID read of the same register in the same cycle SHALL return the new value (write-through).
REQ-012 With no stall or redirect, PC SHALL advance by 4 on every rising edge.
REQ-013 Taken branches and jumps SHALL resolve in EX:
- next PC = target with bits [1:0] forced to 0.
- the instructions in IF/ID and IF are squashed, becoming bubbles.
- penalty is 2 cycles.
REQ-014 JAL/JALR SHALL write PC+4 of the jump instruction to rd; JALR target = (rs1+imm) with bits [1:0] cleared.
REQ-015 Redirect SHALL take priority over stall when both occur in the same cycle.
REQ-016 PC SHALL wrap from 0xFFFFFFFC to 0x00000000.

Reset
REQ-017 On reset, PC, IF/ID, ID/EX, EX/WB and all 32 registers SHALL be 0; pipeline registers hold bubbles.
REQ-018 Asserting reset mid-operation SHALL force PC=0 without waiting for a clock edge.
REQ-019 After reset deasserts, fetch SHALL restart at 0x00000000 on the first rising edge.

Configuration
REQ-020 Macro FORWARDING_EN SHALL select how read-after-write hazards are handled.
REQ-021 With FORWARDING_EN defined: the EX/WB result SHALL be forwarded to EX operands on a destination/source match (rd!=0); no stalls occur.
REQ-022 Without FORWARDING_EN: when an ID source matches the EX destination (rd!=0, writing instruction), the core SHALL stall 1 cycle:
- PC and IF/ID hold.
- a bubble enters EX.
REQ-023 Architectural results SHALL be identical in both builds; only the PC timing differs.

Verification
REQ-024 Reset and sequential fetch: hold reset 3 cycles, then release and feed 0x00000013 continuously -> PC = 0x0, 0x4, 0x8, 0xC on successive edges.
REQ-025 Jump: JAL x0,+16 (0x0100006F) at 0x0, NOPs elsewhere -> PC = 0x0, 0x4, 0x8, 0x10, 0x14.
REQ-026 Dependent branch: ADDI x1,x0,5 (0x00500093) at 0x0, then BNE x1,x0,+32 (0x02009063) at 0x4:
- FORWARDING_EN -> PC = 0x0, 0x4, 0x8, 0xC, 0x24.
- no macro -> PC = 0x0, 0x4, 0x8, 0x8, 0xC, 0x24.
REQ-027 JALR: ADDI x2,x0,0x40 (0x04000113) at 0x0, then JALR x0,0(x2) (0x00010067) at 0x4, with FORWARDING_EN -> PC = 0x0, 0x4, 0x8, 0xC, 0x40.
REQ-028 Not-taken branch: BNE x0,x0,+32 (0x02001063) at 0x0 -> PC = 0x0, 0x4, 0x8, 0xC, 0x10, with no redirect.
REQ-029 Reset mid-run: assert reset while PC=0x24, between clock edges -> PC=0 before the next edge; after release PC = 0x0, 0x4.

Source files
------------

// File: rtl/modport_core_if.sv
// Instruction-fetch bus between modport_core and its instruction memory.
// master = core (drives PC), slave = memory (returns mem_ins).
interface modport_core_if;
  logic [31:0] PC;
  logic [31:0] mem_ins;

  modport master (
    output PC,
    input  mem_ins
  );

  modport slave (
    input  PC,
    output mem_ins
  );
endinterface

// File: rtl/modport_core.sv
// RV32I integer core, 4-stage pipeline IF/ID/EX/WB with branch resolve in EX.
// Define FORWARDING_EN for EX/WB->EX bypass; otherwise RAW hazards stall 1 cycle.
module modport_core (
  input  logic           clock,
  input  logic           reset,
  modport_core_if.master imem
);

  typedef enum logic [2:0] {
    K_NOP, K_ALU, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR
  } kind_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } if_id_t;

  typedef struct packed {
    kind_e       kind;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        use_imm;
    logic        alt;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        we;
`ifdef FORWARDING_EN
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
`endif
  } id_ex_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] res;
  } ex_wb_t;

  logic [31:0] pc_q, pc_d;
  if_id_t      ifid_q, ifid_d;
  id_ex_t      idex_q, idex_d, dec;
  ex_wb_t      exwb_q, exwb_d;
  logic [31:0] rf [32];

  // ---------------- ID ----------------
  logic [31:0] ins;
  logic [6:0]  opc, f7;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_b, imm_j, imm_u;
  logic [31:0] rv1, rv2;
  logic        f7_z, f7_alt;
  logic        op_lui, op_auipc, op_jal, op_jalr;
  logic        op_br, op_imm, op_reg;
  logic        u1, u2, stall;

  assign ins = ifid_q.ins;
  assign opc = ins[6:0];
  assign rd  = ins[11:7];
  assign f3  = ins[14:12];
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];
  assign f7  = ins[31:25];

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};
  assign imm_u = {ins[31:12], 12'h000};

  assign f7_z   = (f7 == 7'h00);
  assign f7_alt = (f7 == 7'h20);

  // Anything not matched here (loads, stores, fence, system,
  // malformed encodings) decodes to a bubble.
  assign op_lui   = (opc == 7'h37);
  assign op_auipc = (opc == 7'h17);
  assign op_jal   = (opc == 7'h6f);
  assign op_jalr  = (opc == 7'h67) && (f3 == 3'b000);
  assign op_br    = (opc == 7'h63) && (f3 != 3'b010)
                    && (f3 != 3'b011);
  assign op_imm   = (opc == 7'h13)
                    && ((f3 == 3'b001) ? f7_z :
                        (f3 == 3'b101) ? (f7_z || f7_alt) :
                        1'b1);
  assign op_reg   = (opc == 7'h33)
                    && (f7_z || (f7_alt && ((f3 == 3'b000)
                                         || (f3 == 3'b101))));

  // Write-through: a WB write is visible to the same-cycle read.
  assign rv1 = (rs1 == 5'd0) ? 32'h0 :
               (exwb_q.we && exwb_q.rd == rs1) ? exwb_q.res :
               rf[rs1];
  assign rv2 = (rs2 == 5'd0) ? 32'h0 :
               (exwb_q.we && exwb_q.rd == rs2) ? exwb_q.res :
               rf[rs2];

  always_comb begin
    dec     = '0;
    u1      = 1'b0;
    u2      = 1'b0;
    dec.pc  = ifid_q.pc;
    dec.a   = rv1;
    dec.b   = rv2;
    dec.f3  = f3;
    dec.rd  = rd;
    unique case (1'b1)
      op_lui: begin
        dec.kind = K_LUI;
        dec.imm  = imm_u;
        dec.we   = 1'b1;
      end
      op_auipc: begin
        dec.kind = K_AUIPC;
        dec.imm  = imm_u;
        dec.we   = 1'b1;
      end
      op_jal: begin
        dec.kind = K_JAL;
        dec.imm  = imm_j;
        dec.we   = 1'b1;
      end
      op_jalr: begin
        dec.kind = K_JALR;
        dec.imm  = imm_i;
        dec.we   = 1'b1;
        u1       = 1'b1;
      end
      op_br: begin
        dec.kind = K_BR;
        dec.imm  = imm_b;
        u1       = 1'b1;
        u2       = 1'b1;
      end
      op_imm: begin
        dec.kind    = K_ALU;
        dec.imm     = imm_i;
        dec.use_imm = 1'b1;
        dec.alt     = (f3 == 3'b101) && ins[30];
        dec.we      = 1'b1;
        u1          = 1'b1;
      end
      op_reg: begin
        dec.kind = K_ALU;
        dec.alt  = ins[30];
        dec.we   = 1'b1;
        u1       = 1'b1;
        u2       = 1'b1;
      end
      default: ;
    endcase
    dec.we = dec.we && (rd != 5'd0);
`ifdef FORWARDING_EN
    dec.rs1 = rs1;
    dec.rs2 = rs2;
    dec.u1  = u1;
    dec.u2  = u2;
`endif
  end

`ifdef FORWARDING_EN
  assign stall = 1'b0;
`else
  assign stall = idex_q.we
                 && ((u1 && idex_q.rd == rs1)
                  || (u2 && idex_q.rd == rs2));
`endif

  // ---------------- EX ----------------
  logic [31:0] op_a, op_b, opnd, alu, res, target;
  logic        taken, redirect;

`ifdef FORWARDING_EN
  assign op_a = (idex_q.u1 && exwb_q.we
                 && exwb_q.rd == idex_q.rs1) ? exwb_q.res : idex_q.a;
  assign op_b = (idex_q.u2 && exwb_q.we
                 && exwb_q.rd == idex_q.rs2) ? exwb_q.res : idex_q.b;
`else
  assign op_a = idex_q.a;
  assign op_b = idex_q.b;
`endif

  assign opnd = idex_q.use_imm ? idex_q.imm : op_b;

  always_comb begin
    unique case (idex_q.f3)
      3'b000: alu = idex_q.alt ? op_a - opnd : op_a + opnd;
      3'b001: alu = op_a << opnd[4:0];
      3'b010: alu = {31'h0, $signed(op_a) < $signed(opnd)};
      3'b011: alu = {31'h0, op_a < opnd};
      3'b100: alu = op_a ^ opnd;
      3'b101: alu = idex_q.alt
                    ? $unsigned($signed(op_a) >>> opnd[4:0])
                    : op_a >> opnd[4:0];
      3'b110: alu = op_a | opnd;
      3'b111: alu = op_a & opnd;
      default: alu = 32'h0;
    endcase
  end

  always_comb begin
    unique case (idex_q.f3)
      3'b000: taken = (op_a == op_b);
      3'b001: taken = (op_a != op_b);
      3'b100: taken = $signed(op_a) < $signed(op_b);
      3'b101: taken = $signed(op_a) >= $signed(op_b);
      3'b110: taken = op_a < op_b;
      3'b111: taken = op_a >= op_b;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    res      = alu;
    target   = idex_q.pc + idex_q.imm;
    redirect = 1'b0;
    unique case (idex_q.kind)
      K_LUI:   res = idex_q.imm;
      K_AUIPC: res = idex_q.pc + idex_q.imm;
      K_JAL: begin
        res      = idex_q.pc + 32'd4;
        redirect = 1'b1;
      end
      K_JALR: begin
        res      = idex_q.pc + 32'd4;
        target   = op_a + idex_q.imm;
        redirect = 1'b1;
      end
      K_BR:    redirect = taken;
      default: ;
    endcase
    target[1:0] = 2'b00;
  end

  assign exwb_d = '{we: idex_q.we, rd: idex_q.rd, res: res};

  // ---------------- IF / next state ----------------
  // A redirect squashes both younger stages and wins over a stall.
  always_comb begin
    pc_d   = pc_q + 32'd4;
    ifid_d = '{pc: pc_q, ins: imem.mem_ins};
    idex_d = dec;
    if (redirect) begin
      pc_d   = target;
      ifid_d = '0;
      idex_d = '0;
    end else if (stall) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      idex_d = '0;
    end
  end

  assign imem.PC = pc_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q   <= 32'h0;
      ifid_q <= '0;
      idex_q <= '0;
      exwb_q <= '0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      idex_q <= idex_d;
      exwb_q <= exwb_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (exwb_q.we) begin
      rf[exwb_q.rd] <= exwb_q.res;
    end
  end

endmodule

// File: tb/tb_modport_core.sv
// Directed bench for modport_core: PC traces for fetch/jump/branch/reset,
// plus a self-checking RV32I program that traps to 0x800 on any wrong result.
module tb_modport_core;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] TRAP = 32'h00000800;

  logic clock = 1'b0;
  logic reset = 1'b1;

  modport_core_if bus ();

  modport_core dut (
    .clock (clock),
    .reset (reset),
    .imem  (bus)
  );

  always #5 clock = ~clock;

  logic [31:0] rom [1024];
  logic [31:0] apc;
  logic [31:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  always_comb
    bus.mem_ins = (bus.PC[31:12] == 20'h0) ? rom[bus.PC[11:2]] : NOP;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(
    input logic [12:0] off, input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [20:0] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_u(
    input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = NOP;
    apc = 32'h0;
  endtask

  task automatic emit(input logic [31:0] w);
    rom[apc[11:2]] = w;
    apc = apc + 32'd4;
  endtask

  task automatic li(input logic [4:0] rd, input logic [31:0] v);
    logic [31:0] hi;
    hi = v + 32'h800;
    emit(enc_u(hi[31:12], rd, 7'h37));
    emit(enc_i(v[11:0], rd, 3'b000, rd, 7'h13));
  endtask

  task automatic jump_trap();
    logic [31:0] off;
    off = TRAP - apc;
    emit(enc_j(off[20:0], 5'd0));
  endtask

  task automatic asm_expect(input logic [4:0] rs, input logic [31:0] v);
    logic [31:0] off;
    li(5'd31, v);
    off = TRAP - apc;
    emit(enc_b(off[12:0], 5'd31, rs, 3'b001));
  endtask

  task automatic asm_r(input logic [6:0] f7, input logic [2:0] f3,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] v);
    emit(enc_r(f7, rs2, rs1, f3, 5'd3));
    asm_expect(5'd3, v);
  endtask

  task automatic asm_i(input logic [11:0] imm, input logic [2:0] f3,
                       input logic [4:0] rs1, input logic [31:0] v);
    emit(enc_i(imm, rs1, f3, 5'd3, 7'h13));
    asm_expect(5'd3, v);
  endtask

  task automatic asm_taken(input logic [2:0] f3, input logic [4:0] rs1,
                           input logic [4:0] rs2);
    emit(enc_b(13'd8, rs2, rs1, f3));
    jump_trap();
  endtask

  task automatic asm_not_taken(input logic [2:0] f3, input logic [4:0] rs1,
                               input logic [4:0] rs2);
    logic [31:0] off;
    off = TRAP - apc;
    emit(enc_b(off[12:0], rs2, rs1, f3));
  endtask

  task automatic start();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 check("rst_pc", bus.PC, 32'h0);
    @(negedge clock) reset = 1'b0;
  endtask

  task automatic run_seq(input string tag);
    check($sformatf("%s_0", tag), bus.PC, exp_q[0]);
    for (int i = 1; i < exp_q.size(); i++) begin
      @(posedge clock);
      #1 check($sformatf("%s_%0d", tag, i), bus.PC, exp_q[i]);
    end
  endtask

  initial begin
    logic [31:0] a, t, pass_pc;
    logic hit_pass, hit_trap, found;

    clear_rom();
    start();
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC};
    run_seq("seq");

    clear_rom();
    rom[0] = 32'h0100006F;
    start();
    exp_q = {32'h0, 32'h4, 32'h8, 32'h10, 32'h14};
    run_seq("jal");

    clear_rom();
    rom[0] = 32'h00500093;
    rom[1] = 32'h02009063;
    start();
`ifdef FORWARDING_EN
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC, 32'h24};
`else
    exp_q = {32'h0, 32'h4, 32'h8, 32'h8, 32'hC, 32'h24};
`endif
    run_seq("dep_bne");

    clear_rom();
    rom[0] = 32'h04000113;
    rom[1] = 32'h00010067;
    start();
`ifdef FORWARDING_EN
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC, 32'h40};
`else
    exp_q = {32'h0, 32'h4, 32'h8, 32'h8, 32'hC, 32'h40};
`endif
    run_seq("jalr");

    clear_rom();
    rom[0] = 32'h02001063;
    start();
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    run_seq("bne_nt");

    clear_rom();
    rom[0] = enc_i(12'hFFC, 5'd0, 3'b000, 5'd1, 7'h13);
    rom[1] = enc_i(12'h000, 5'd1, 3'b000, 5'd0, 7'h67);
    start();
`ifdef FORWARDING_EN
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC, 32'hFFFFFFFC, 32'h0};
`else
    exp_q = {32'h0, 32'h4, 32'h8, 32'h8, 32'hC, 32'hFFFFFFFC, 32'h0};
`endif
    run_seq("wrap");

    // Asynchronous reset in the middle of a run.
    clear_rom();
    rom[0] = 32'h00500093;
    rom[1] = 32'h02009063;
    start();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clock);
      #1 found = (bus.PC == 32'h24);
    end
    check("reach_24", bus.PC, 32'h24);
    #2 reset = 1'b1;
    #1 check("async_rst", bus.PC, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    exp_q = {32'h0, 32'h4};
    run_seq("post_rst");

    // Self-checking instruction program.
    clear_rom();
    li(5'd1, 32'h80000005);
    li(5'd2, 32'hFFFFFFFD);
    li(5'd7, 32'd36);
    asm_r(7'h00, 3'b000, 5'd1, 5'd2, 32'h80000002);
    asm_r(7'h00, 3'b000, 5'd1, 5'd1, 32'h0000000A);
    asm_r(7'h20, 3'b000, 5'd1, 5'd2, 32'h80000008);
    asm_r(7'h00, 3'b001, 5'd1, 5'd7, 32'h00000050);
    asm_r(7'h00, 3'b010, 5'd1, 5'd2, 32'h00000001);
    asm_r(7'h00, 3'b011, 5'd2, 5'd1, 32'h00000000);
    asm_r(7'h00, 3'b011, 5'd1, 5'd2, 32'h00000001);
    asm_r(7'h00, 3'b100, 5'd1, 5'd2, 32'h7FFFFFF8);
    asm_r(7'h00, 3'b101, 5'd1, 5'd7, 32'h08000000);
    asm_r(7'h20, 3'b101, 5'd1, 5'd7, 32'hF8000000);
    asm_r(7'h00, 3'b110, 5'd1, 5'd2, 32'hFFFFFFFD);
    asm_r(7'h00, 3'b111, 5'd1, 5'd7, 32'h00000004);
    asm_i(12'hFFA, 3'b000, 5'd1, 32'h7FFFFFFF);
    asm_i(12'hFFE, 3'b010, 5'd2, 32'h00000001);
    asm_i(12'h005, 3'b011, 5'd1, 32'h00000000);
    asm_i(12'h0F0, 3'b100, 5'd1, 32'h800000F5);
    asm_i(12'h00A, 3'b110, 5'd1, 32'h8000000F);
    asm_i(12'h0F0, 3'b111, 5'd2, 32'h000000F0);
    asm_i(12'h001, 3'b001, 5'd1, 32'h0000000A);
    asm_i(12'h01F, 3'b101, 5'd1, 32'h00000001);
    asm_i(12'h401, 3'b101, 5'd2, 32'hFFFFFFFE);
    asm_i(12'h404, 3'b101, 5'd1, 32'hF8000000);
    asm_taken(3'b000, 5'd1, 5'd1);
    asm_taken(3'b001, 5'd1, 5'd2);
    asm_taken(3'b100, 5'd1, 5'd2);
    asm_taken(3'b101, 5'd2, 5'd1);
    asm_taken(3'b101, 5'd1, 5'd1);
    asm_taken(3'b110, 5'd1, 5'd2);
    asm_taken(3'b111, 5'd2, 5'd1);
    asm_not_taken(3'b000, 5'd1, 5'd2);
    asm_not_taken(3'b001, 5'd1, 5'd1);
    asm_not_taken(3'b100, 5'd2, 5'd1);
    asm_not_taken(3'b101, 5'd1, 5'd2);
    asm_not_taken(3'b110, 5'd2, 5'd1);
    asm_not_taken(3'b111, 5'd1, 5'd2);
    a = apc;
    emit(enc_u(20'h00001, 5'd3, 7'h17));
    asm_expect(5'd3, a + 32'h1000);
    a = apc;
    emit(enc_j(21'd8, 5'd5));
    jump_trap();
    asm_expect(5'd5, a + 32'd4);
    t = apc + 32'd16;
    li(5'd8, t);
    a = apc;
    emit(enc_i(12'h001, 5'd8, 3'b000, 5'd9, 7'h67));
    jump_trap();
    asm_expect(5'd9, a + 32'd4);
    li(5'd3, 32'h12345678);
    emit(32'h00002183);
    emit(32'h00102023);
    emit(32'h0000000F);
    emit(32'h00000073);
    emit(32'h0000018B);
    asm_expect(5'd3, 32'h12345678);
    emit(enc_i(12'h005, 5'd0, 3'b000, 5'd0, 7'h13));
    emit(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd0));
    asm_expect(5'd0, 32'h0);
    pass_pc = apc + 32'd16;

    start();
    hit_pass = 1'b0;
    hit_trap = 1'b0;
    for (int i = 0; i < 1000 && !hit_pass && !hit_trap; i++) begin
      @(posedge clock);
      #1;
      hit_pass = (bus.PC == pass_pc);
      hit_trap = (bus.PC >= TRAP) && (bus.PC < TRAP + 32'h100);
    end
    check("prog_pass", {31'h0, hit_pass}, 32'h1);
    check("prog_trap", {31'h0, hit_trap}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
